// File: rtl/dco_pkg.sv
// dco_pkg: shared definitions for the dco_nco oscillator.
//   dco_state_t : oscillator state (IDLE, RUN, SLEW)
//   LFSR_SEED   : reset value of the dither LFSR
//   LFSR_TAPS   : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   fcw_sat()   : target FCW = base + gain*code, saturated to 2^(acc_width-1)-1
package dco_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SLEW = 2'd2
   } dco_state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // 64-bit arithmetic covers any ACC_WIDTH+CTRL_WIDTH sum used in practice;
   // the saturation limit keeps the output strictly below f_clk/2.
   function automatic logic [63:0] fcw_sat(
      input logic [63:0] base,
      input logic [63:0] gain,
      input logic [63:0] code,
      input int unsigned acc_width
   );
      logic [63:0] sum;
      logic [63:0] fmax;
      sum  = base + gain * code;
      fmax = (64'd1 << (acc_width - 1)) - 64'd1;
      return (sum > fmax) ? fmax : sum;
   endfunction

endpackage

// File: rtl/dco_lfsr16.sv
// dco_lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) used for accumulator
// dither. Only compiled when DCO_DITHER_EN is defined.
//   clk     : system clock
//   rst     : asynchronous active-high reset, loads LFSR_SEED
//   adv     : advance the sequence by one step this cycle
//   bit_out : LSB of the current LFSR state
`ifdef DCO_DITHER_EN
module dco_lfsr16
   import dco_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic adv,
   output logic bit_out
);

   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else if (adv) begin
         lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      end
   end

   assign bit_out = lfsr[0];

endmodule
`endif

// File: rtl/dco_nco.sv
// dco_nco: digitally-controlled oscillator on a phase accumulator.
// Output frequency = f_clk * fcw / 2^ACC_WIDTH. The control code sets a target
// FCW (FCW_BASE + FCW_GAIN*code, saturated); the current FCW slews toward it by
// at most SLEW_STEP per cycle. Optional dither: define DCO_DITHER_EN.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   en         : oscillator run enable
//   ctrl_code  : control code (unsigned)
//   ctrl_valid : ctrl_code is valid
//   ctrl_ready : a new code can be accepted (low while slewing)
//   clk_out    : accumulator MSB
//   tick       : one-cycle pulse after each accumulator wrap
//   settled    : current FCW equals target FCW
//   fcw_out    : current FCW
module dco_nco
   import dco_pkg::*;
#(
   parameter int unsigned ACC_WIDTH  = 16,
   parameter int unsigned CTRL_WIDTH = 8,
   parameter int unsigned FCW_BASE   = 256,
   parameter int unsigned FCW_GAIN   = 64,
   parameter int unsigned SLEW_STEP  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [CTRL_WIDTH-1:0] ctrl_code,
   input  logic                  ctrl_valid,
   output logic                  ctrl_ready,
   output logic                  clk_out,
   output logic                  tick,
   output logic                  settled,
   output logic [ACC_WIDTH-1:0]  fcw_out
);

   localparam logic [ACC_WIDTH-1:0] BASE = ACC_WIDTH'(FCW_BASE);
   localparam logic [ACC_WIDTH-1:0] STEP = ACC_WIDTH'(SLEW_STEP);

   dco_state_t           state;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] fcw_cur;
   logic [ACC_WIDTH-1:0] fcw_tgt;
   logic [ACC_WIDTH-1:0] tgt_sat;
   logic [ACC_WIDTH-1:0] tgt_nx;
   logic [ACC_WIDTH-1:0] cur_nx;
   logic [ACC_WIDTH:0]   sum;
   logic                 accept;
   logic                 running;
   logic                 cin;

   assign ctrl_ready = (state != SLEW);
   assign accept     = ctrl_valid && ctrl_ready;
   assign tgt_sat    = ACC_WIDTH'(fcw_sat(64'(FCW_BASE), 64'(FCW_GAIN),
                                          64'(ctrl_code), ACC_WIDTH));
   assign tgt_nx     = accept ? tgt_sat : fcw_tgt;
   assign running    = en && (state != IDLE);

   // Accumulator step uses fcw_cur before this cycle's slew update.
   assign sum = {1'b0, acc} + {1'b0, fcw_cur} + {{ACC_WIDTH{1'b0}}, cin};

`ifdef DCO_DITHER_EN
   dco_lfsr16 u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .adv     (running),
      .bit_out (cin)
   );
`else
   assign cin = 1'b0;
`endif

   always_comb begin
      cur_nx = fcw_cur;
      if (running && (state == SLEW)) begin
         if (fcw_tgt > fcw_cur) begin
            cur_nx = ((fcw_tgt - fcw_cur) <= STEP) ? fcw_tgt : fcw_cur + STEP;
         end else begin
            cur_nx = ((fcw_cur - fcw_tgt) <= STEP) ? fcw_tgt : fcw_cur - STEP;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         fcw_cur <= BASE;
         fcw_tgt <= BASE;
         tick    <= 1'b0;
         settled <= 1'b1;
      end else begin
         fcw_tgt <= tgt_nx;
         fcw_cur <= cur_nx;
         settled <= (cur_nx == tgt_nx);
         if (!en) begin
            // Disable wins over any accepted code; fcw_cur stays frozen.
            state <= IDLE;
            acc   <= '0;
            tick  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  acc   <= '0;
                  tick  <= 1'b0;
                  state <= (cur_nx == tgt_nx) ? RUN : SLEW;
               end
               RUN: begin
                  acc  <= sum[ACC_WIDTH-1:0];
                  tick <= sum[ACC_WIDTH];
                  if (tgt_nx != fcw_cur) state <= SLEW;
               end
               SLEW: begin
                  acc  <= sum[ACC_WIDTH-1:0];
                  tick <= sum[ACC_WIDTH];
                  if (cur_nx == fcw_tgt) state <= RUN;
               end
               default: begin
                  state <= IDLE;
                  acc   <= '0;
                  tick  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign clk_out = acc[ACC_WIDTH-1];
   assign fcw_out = fcw_cur;

endmodule

// File: doc/dco_nco.md
Name: dco_nco

Overview:
- Synthesisable, parametrised successor to the real-valued VCO model: a digitally-controlled oscillator built on a phase accumulator.
- A digital control code replaces the analog control voltage. The code sets a target frequency-control word (FCW) as FCW_BASE + FCW_GAIN*code.
- The FCW is slew-limited toward the target, and the oscillator produces a square clock, a wrap tick and a settled flag.
- Sits between a digital loop filter (PLL/DLL lab) and the clocked logic that consumes clk_out.

Parameters:
- ACC_WIDTH, 16, phase accumulator width in bits; output frequency = f_clk*fcw/2^ACC_WIDTH.
- CTRL_WIDTH, 8, control code width (unsigned).
- FCW_BASE, 256, intrinsic FCW at code 0; analog of INTRINSIC_FREQ.
- FCW_GAIN, 64, FCW increment per control code LSB; analog of VCO_GAIN.
- SLEW_STEP, 32, maximum change of the current FCW per clock cycle.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  oscillator run enable.
- ctrl_code  in  CTRL_WIDTH  control code.
- ctrl_valid  in  1  ctrl_code is valid.
- ctrl_ready  out  1  new code can be accepted.
- clk_out  out  1  oscillator output (accumulator MSB).
- tick  out  1  one-cycle pulse per accumulator wrap.
- settled  out  1  current FCW equals the target FCW.
- fcw_out  out  ACC_WIDTH  current FCW, for readback.

Behaviour:
- Reset (asynchronous, any time, including mid-slew):
  - acc=0, fcw_cur=fcw_tgt=FCW_BASE, state=IDLE.
  - clk_out=0, tick=0, settled=1, ctrl_ready=1, fcw_out=FCW_BASE.
- Target computation:
  - Sum = FCW_BASE + FCW_GAIN*ctrl_code, computed at width ACC_WIDTH+CTRL_WIDTH.
  - Saturated to FCW_MAX = 2^(ACC_WIDTH-1)-1, which keeps the output below f_clk/2.
- Handshake:
  - A code is accepted on the rising clk edge where ctrl_valid && ctrl_ready; fcw_tgt updates on that edge.
  - ctrl_ready = (state != SLEW), driven combinationally from the state register.
  - Codes are accepted in IDLE as well as in RUN.
- States:
  - IDLE: acc held at 0, clk_out=0, no ticks.
    - en=1 → RUN if fcw_cur==fcw_tgt, else → SLEW.
  - RUN: acc += fcw_cur every cycle.
    - Accepted code with a new target differing from fcw_cur → SLEW.
    - en=0 → IDLE.
  - SLEW: acc += fcw_cur every cycle; fcw_cur moves toward fcw_tgt by SLEW_STEP.
    - If |fcw_tgt−fcw_cur| ≤ SLEW_STEP, fcw_cur=fcw_tgt and the state goes → RUN.
    - en=0 → IDLE; fcw_cur is frozen at its current value and resumes slewing on the next enable.
- Accumulator update: uses the fcw_cur register value before that cycle's slew update. Addition is modulo 2^ACC_WIDTH.
- tick: registered carry-out of the accumulator addition, high exactly one cycle after each wrap.
- settled = (fcw_cur == fcw_tgt), registered.
- Simultaneous events:
  - en=0 has priority over code acceptance for the state transition.
  - The accepted code still updates fcw_tgt.
  - An accept in the same cycle that SLEW completes is impossible, because ready=0 during SLEW.

Optional Feature:
- Macro DCO_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle in RUN/SLEW.
  - Its LSB is added as carry-in to the accumulator, giving +0.5 LSB average FCW and spreading spurs.
- Undefined: no LFSR, carry-in = 0, fully deterministic period.

Decomposition:
- Package dco_pkg holds:
  - the state enum typedef (IDLE, RUN, SLEW);
  - LFSR_SEED and LFSR tap constants;
  - a function fcw_sat() for saturating target computation.
- One sub-module, dco_lfsr16 (clk, rst, adv, bit_out), instantiated only under DCO_DITHER_EN.

Test Plan (all with dither off unless stated):
1. Reset, then en=1 with no code → acc steps by 256, tick every 65536/256=256 cycles, clk_out 50% duty at 128 cycles high/low, settled=1.
2. ctrl_code=4, valid in RUN → fcw_tgt=512; ctrl_ready low 8 cycles while fcw_out steps 288,320,…,512; settled rises after that; tick period becomes 128 cycles.
3. FCW_GAIN=1024 override, code=255 → fcw_tgt saturates to 32767, no overflow; fcw_out reaches 32767 after ceil((32767−256)/32)=1016 cycles.
4. en=0 mid-slew at fcw_out=384 → IDLE, clk_out=0, acc=0, fcw_out holds 384; en=1 → slewing resumes from 384.
5. rst pulse mid-SLEW (async, between edges) → all outputs immediately at reset values, state IDLE.
6. DCO_DITHER_EN defined, fcw=256 → mean tick period over 64 wraps lies in [255,256] cycles; the LFSR sequence matches the reference seed 16'hACE1.
